// File: rtl/or4_rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// ANY_REQ is a zero-latency OR of REQ; all grant outputs are registered.
module or4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             CK,
  input  logic             RN,
  input  logic [3:0]       REQ,
  input  logic             DONE,
  output logic [3:0]       GNT,
  output logic             GNT_VLD,
  output logic [1:0]       GNT_ID,
  output logic             ANY_REQ,
  output logic             dbg_state,
  output logic [1:0]       dbg_pri,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       pri_q, pri_d;
  logic [1:0]       id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic             rel;

  // Scan downwards so the lowest offset from pri (highest priority) wins.
  function automatic logic [1:0] pick(input logic [1:0] pri, input logic [3:0] req);
    logic [1:0] idx;
    pick = pri;
    for (int i = 3; i >= 0; i--) begin
      idx = pri + 2'(i);
      if (req[idx]) pick = idx;
    end
  endfunction

  assign ANY_REQ = |REQ;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      pri_q   <= 2'd0;
      id_q    <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pri_q   <= pri_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    rel     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ANY_REQ) begin
          state_d = GRANT;
          id_d    = pick(pri_q, REQ);
          gnt_d   = 4'b0001 << id_d;
          vld_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        rel = DONE || !REQ[id_q] || (cnt_q == CNT_MAX);
        if (rel) begin
          // Rotate past the releasing requester, then regrant on the same edge.
          pri_d = id_q + 2'd1;
          cnt_d = '0;
          if (ANY_REQ) begin
            id_d  = pick(pri_d, REQ);
            gnt_d = 4'b0001 << id_d;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            vld_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign GNT       = gnt_q;
  assign GNT_VLD   = vld_q;
  assign GNT_ID    = id_q;
  assign dbg_state = state_q;
  assign dbg_pri   = pri_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_or4_rr_arbiter.sv
// Directed bench for or4_rr_arbiter: reset, rotation, timeout, sole requester,
// idle drop, async reset mid-grant, and a MAX_HOLD=1 instance.
module tb_or4_rr_arbiter;

  logic       CK;
  logic       RN;
  logic [3:0] REQ;
  logic       DONE;

  logic [3:0] gnt;
  logic       gnt_vld;
  logic [1:0] gnt_id;
  logic       any_req;
  logic       dbg_state;
  logic [1:0] dbg_pri;
  logic [3:0] dbg_cnt;

  logic [3:0] h1_gnt;
  logic       h1_vld;
  logic [1:0] h1_id;
  logic       h1_any;
  logic       h1_state;
  logic [1:0] h1_pri;
  logic [0:0] h1_cnt;

  int n_checks;
  int n_pass;

  or4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut (
    .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
    .GNT(gnt), .GNT_VLD(gnt_vld), .GNT_ID(gnt_id), .ANY_REQ(any_req),
    .dbg_state(dbg_state), .dbg_pri(dbg_pri), .dbg_cnt(dbg_cnt)
  );

  or4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(1)) u_dut_h1 (
    .CK(CK), .RN(RN), .REQ(REQ), .DONE(DONE),
    .GNT(h1_gnt), .GNT_VLD(h1_vld), .GNT_ID(h1_id), .ANY_REQ(h1_any),
    .dbg_state(h1_state), .dbg_pri(h1_pri), .dbg_cnt(h1_cnt)
  );

  // clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic v);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".id"},  32'(gnt_id), 32'(id));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(v));
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  logic [3:0] rot_gnt [4];
  logic [1:0] rot_id  [4];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rot_gnt  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_id   = '{2'd1, 2'd2, 2'd3, 2'd0};
    RN   = 1'b0;
    REQ  = 4'b1111;
    DONE = 1'b0;

    // reset and first grant
    #3;
    expect_grant("rst", 4'b0000, 2'd0, 1'b0);
    check("rst.any_req", 32'(any_req), 32'd1);
    check("rst.state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge CK);
    #2 RN = 1'b1;
    step();
    expect_grant("first", 4'b0001, 2'd0, 1'b1);

    // rotation with DONE every cycle
    DONE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_grant($sformatf("rot%0d", i), rot_gnt[i], rot_id[i], 1'b1);
    end
    DONE = 1'b0;

    // timeout: 8 cycles each for A1 and A2
    REQ = 4'b0011;
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("to_a1_%0d.gnt", k), 32'(gnt), 32'(4'b0001));
      check($sformatf("to_a1_%0d.cnt", k), 32'(dbg_cnt), 32'(k));
    end
    step();
    expect_grant("to_a2", 4'b0010, 2'd1, 1'b1);
    check("to_a2.cnt", 32'(dbg_cnt), 32'd0);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("to_a2_%0d.gnt", k), 32'(gnt), 32'(4'b0010));
    end
    step();
    expect_grant("to_back", 4'b0001, 2'd0, 1'b1);

    // sole requester A3
    REQ = 4'b0100;
    step();
    expect_grant("sole", 4'b0100, 2'd2, 1'b1);
    check("sole.pri", 32'(dbg_pri), 32'd1);
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("sole_%0d.gnt", k), 32'(gnt), 32'(4'b0100));
      check($sformatf("sole_%0d.cnt", k), 32'(dbg_cnt), 32'(k));
    end
    step();
    expect_grant("sole_wrap", 4'b0100, 2'd2, 1'b1);
    check("sole_wrap.cnt", 32'(dbg_cnt), 32'd0);
    check("sole_wrap.pri", 32'(dbg_pri), 32'd3);
    for (int k = 1; k < 8; k++) step();
    step();
    check("sole_wrap2.cnt", 32'(dbg_cnt), 32'd0);
    check("sole_wrap2.vld", 32'(gnt_vld), 32'd1);

    // drop to idle
    REQ = 4'b0010;
    step();
    expect_grant("pre_idle", 4'b0010, 2'd1, 1'b1);
    REQ = 4'b0000;
    #1;
    check("idle.any_req", 32'(any_req), 32'd0);
    check("idle.gnt_held", 32'(gnt), 32'(4'b0010));
    step();
    expect_grant("idle", 4'b0000, 2'd1, 1'b0);
    check("idle.state", 32'(dbg_state), 32'd0);
    check("idle.pri", 32'(dbg_pri), 32'd2);
    DONE = 1'b1;
    step();
    expect_grant("idle_done", 4'b0000, 2'd1, 1'b0);
    check("idle_done.pri", 32'(dbg_pri), 32'd2);
    DONE = 1'b0;
    REQ  = 4'b1000;
    step();
    expect_grant("wake", 4'b1000, 2'd3, 1'b1);

    // async reset mid-grant
    REQ = 4'b0100;
    step();
    expect_grant("pre_rst", 4'b0100, 2'd2, 1'b1);
    #2 RN = 1'b0;
    #1;
    expect_grant("async_rst", 4'b0000, 2'd0, 1'b0);
    check("async_rst.state", 32'(dbg_state), 32'd0);
    check("async_rst.cnt", 32'(dbg_cnt), 32'd0);
    REQ = 4'b1111;
    step();
    expect_grant("in_rst", 4'b0000, 2'd0, 1'b0);
    #2 RN = 1'b1;
    step();
    expect_grant("post_rst", 4'b0001, 2'd0, 1'b1);
    check("h1_first", 32'(h1_gnt), 32'(4'b0001));

    // MAX_HOLD=1 rotates every cycle; MAX_HOLD=8 keeps its grant
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("h1_rot%0d", i), 32'(h1_gnt), 32'(rot_gnt[i]));
      check($sformatf("h1_rot%0d.vld", i), 32'(h1_vld), 32'd1);
      check($sformatf("h8_hold%0d", i), 32'(gnt), 32'(4'b0001));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
